// File: rtl/seq_bit_feeder_pkg.sv
// Shared definitions for the serial bit feeder and the sequence detector it drives.
// State encodings and default sizes live here so both sides agree on them.
package seq_bit_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int WORD_W_DEF    = 16;
  localparam int CNT_W_DEF     = 5;
  localparam int DEB_W_DEF     = 20;
  localparam int DEB_LIMIT_DEF = 500000;

endpackage

// File: rtl/seq_bit_feeder_if.sv
// Load/step controls and serial output of the bit feeder.
// The slave side is the feeder itself; the master side is whatever drives it.
interface seq_bit_feeder_if
  import seq_bit_feeder_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic              load;
  logic [WORD_W-1:0] data_in;
  logic              step_btn;
  logic              bit_out;
  logic              bit_valid;
  logic [CNT_W-1:0]  bits_left;
  logic              busy;
  logic              done;

  modport master (
    output load,
    output data_in,
    output step_btn,
    input  bit_out,
    input  bit_valid,
    input  bits_left,
    input  busy,
    input  done
  );

  modport slave (
    input  load,
    input  data_in,
    input  step_btn,
    output bit_out,
    output bit_valid,
    output bits_left,
    output busy,
    output done
  );

endinterface

// File: rtl/seq_bit_feeder_btn_debounce.sv
// Push-button synchroniser and debouncer producing a single-cycle press pulse.
// A level change is accepted only after DEB_LIMIT consecutive stable samples.
module btn_debounce
  import seq_bit_feeder_pkg::*;
#(
  parameter int DEB_W     = DEB_W_DEF,
  parameter int DEB_LIMIT = DEB_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_pulse
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_LIMIT - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic             level_next;
  logic [DEB_W-1:0] cnt;
  logic [DEB_W-1:0] cnt_next;
  logic             pulse_next;

  // Any sample agreeing with the accepted level restarts the stability count.
  always_comb begin
    level_next = level;
    cnt_next   = '0;
    pulse_next = 1'b0;
    if (sync_p1 != level) begin
      if (cnt == CNT_LAST) begin
        level_next = ~level;
        pulse_next = ~level;
      end else begin
        cnt_next = cnt + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0   <= 1'b0;
      sync_p1   <= 1'b0;
      level     <= 1'b0;
      cnt       <= '0;
      btn_pulse <= 1'b0;
    end else begin
      sync_p0   <= btn_raw;
      sync_p1   <= sync_p0;
      level     <= level_next;
      cnt       <= cnt_next;
      btn_pulse <= pulse_next;
    end
  end

endmodule

// File: rtl/seq_bit_feeder.sv
// Serial stimulus source: shifts a loaded test word out MSB-first, one bit per
// debounced button press, with a one-cycle strobe marking each new bit.
module seq_bit_feeder
  import seq_bit_feeder_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DEB_W     = DEB_W_DEF,
  parameter int DEB_LIMIT = DEB_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  seq_bit_feeder_if.slave  bus
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] ONE_LEFT   = CNT_W'(1);

  state_t            state;
  state_t            state_next;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] shreg_next;
  logic [CNT_W-1:0]  bits_left;
  logic [CNT_W-1:0]  bits_left_next;
  logic              bit_out;
  logic              bit_out_next;
  logic              bit_valid;
  logic              bit_valid_next;
  logic              step_pulse;

  btn_debounce #(
    .DEB_W     (DEB_W),
    .DEB_LIMIT (DEB_LIMIT)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (bus.step_btn),
    .btn_pulse (step_pulse)
  );

  // Load wins over a coincident press; that press is simply lost.
  always_comb begin
    state_next     = state;
    shreg_next     = shreg;
    bits_left_next = bits_left;
    bit_out_next   = bit_out;
    bit_valid_next = 1'b0;
    if (bus.load) begin
      shreg_next     = bus.data_in;
      bits_left_next = FULL_COUNT;
      state_next     = ST_ARMED;
    end else if (state == ST_ARMED && step_pulse && bits_left != '0) begin
      bit_out_next   = shreg[WORD_W-1];
      shreg_next     = {shreg[WORD_W-2:0], 1'b0};
      bits_left_next = bits_left - ONE_LEFT;
      bit_valid_next = 1'b1;
      if (bits_left == ONE_LEFT) begin
        state_next = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bits_left <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
    end else begin
      state     <= state_next;
      shreg     <= shreg_next;
      bits_left <= bits_left_next;
      bit_out   <= bit_out_next;
      bit_valid <= bit_valid_next;
    end
  end

  assign bus.bit_out   = bit_out;
  assign bus.bit_valid = bit_valid;
  assign bus.bits_left = bits_left;
  assign bus.busy      = (state == ST_ARMED);
  assign bus.done      = (state == ST_DONE);

endmodule

// File: tb/tb_seq_bit_feeder.sv
// Bench for seq_bit_feeder: queue-based word model feeds a scoreboard that a
// negedge monitor drains on every bit_valid strobe.
module tb_seq_bit_feeder;
  import seq_bit_feeder_pkg::*;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 5;
  localparam int DEB    = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seq_bit_feeder_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

  seq_bit_feeder #(
    .WORD_W    (WORD_W),
    .CNT_W     (CNT_W),
    .DEB_W     (20),
    .DEB_LIMIT (DEB)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic b;
    int   left;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  logic word_q[$];
  bit   armed = 1'b0;
  logic hold_bit = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference model: the loaded word is a queue of bits still to be sent.
  task automatic m_load(input logic [WORD_W-1:0] w);
    word_q.delete();
    for (int i = WORD_W - 1; i >= 0; i--) word_q.push_back(w[i]);
    armed = 1'b1;
  endtask

  task automatic m_press(input int ecyc);
    exp_t e;
    if (armed && word_q.size() > 0) begin
      e.b    = word_q.pop_front();
      e.left = word_q.size();
      e.cyc  = ecyc;
      sb.push_back(e);
    end
  endtask

  task automatic m_reset();
    word_q.delete();
    sb.delete();
    armed    = 1'b0;
    hold_bit = 1'b0;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'(armed && word_q.size() > 0));
    chk({tag, "_done"}, 32'(bus.done), 32'(armed && word_q.size() == 0));
    chk({tag, "_bits_left"}, 32'(bus.bits_left), 32'(word_q.size()));
  endtask

  // Monitor: every strobe must match the oldest expected bit, at its cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("strobe_missing", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
      if (bus.bit_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("bit_out", 32'(bus.bit_out), 32'(e.b));
          chk("strobe_bits_left", 32'(bus.bits_left), 32'(e.left));
          chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
          hold_bit = e.b;
        end
      end else begin
        chk("bit_out_hold", 32'(bus.bit_out), 32'(hold_bit));
      end
    end
  end

  task automatic do_load(input logic [WORD_W-1:0] w);
    @(posedge clk); #1;
    bus.load    = 1'b1;
    bus.data_in = w;
    @(posedge clk); #1;
    bus.load    = 1'b0;
    bus.data_in = WORD_W'($urandom);
    m_load(w);
    chk("load_bits_left", 32'(bus.bits_left), 32'(WORD_W));
    chk("load_busy", 32'(bus.busy), 32'd1);
    chk("load_done", 32'(bus.done), 32'd0);
  endtask

  // One button press; the strobe is due 3+DEB cycles after the final rise.
  task automatic press(input bit bouncy, input bit collide, input logic [WORD_W-1:0] w);
    int t0;
    @(posedge clk); #1;
    if (bouncy) begin
      repeat (3) begin
        bus.step_btn = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.step_btn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
    end
    bus.step_btn = 1'b1;
    t0 = cyc;
    if (collide) begin
      repeat (DEB + 2) @(posedge clk);
      #1;
      bus.load    = 1'b1;
      bus.data_in = w;
      @(posedge clk); #1;
      bus.load    = 1'b0;
      m_load(w);
      chk("collide_bits_left", 32'(bus.bits_left), 32'(WORD_W));
      repeat (DEB + 4) @(posedge clk);
      #1;
    end else begin
      m_press(t0 + 3 + DEB);
      repeat (DEB + 8) @(posedge clk);
      #1;
    end
    if (bouncy) begin
      repeat (2) begin
        bus.step_btn = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.step_btn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
      end
    end
    bus.step_btn = 1'b0;
    repeat (DEB + 8) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [WORD_W-1:0] w;
    int n;
    bus.load     = 1'b0;
    bus.data_in  = '0;
    bus.step_btn = 1'b0;

    // 1: reset held with a toggling button, then presses with no load
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      bus.step_btn = ~bus.step_btn;
    end
    bus.step_btn = 1'b0;
    chk("rst_bit_out", 32'(bus.bit_out), 32'd0);
    chk("rst_bit_valid", 32'(bus.bit_valid), 32'd0);
    chk("rst_bits_left", 32'(bus.bits_left), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    repeat (DEB + 4) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) press(1'b0, 1'b0, '0);
    chk_status("idle");

    // 2: known word, sixteen presses plus one extra
    do_load(16'hB2C5);
    for (int i = 0; i < WORD_W; i++) press(1'b0, 1'b0, '0);
    chk_status("b2c5_end");
    press(1'b0, 1'b0, '0);
    chk_status("b2c5_extra");

    // 6: reload straight from DONE
    do_load(16'h0001);
    for (int i = 0; i < WORD_W; i++) press(1'b0, 1'b0, '0);
    chk_status("reload_end");

    // 3: bouncy press and release
    do_load(WORD_W'($urandom));
    press(1'b1, 1'b0, '0);
    chk_status("bounce");

    // 4: load coinciding with the press pulse at bits_left 9
    do_load(WORD_W'($urandom));
    repeat (7) press(1'b0, 1'b0, '0);
    chk("pre_collide_bits_left", 32'(bus.bits_left), 32'd9);
    press(1'b0, 1'b1, 16'h8001);
    press(1'b0, 1'b0, '0);
    chk_status("after_collide");

    // 5: asynchronous reset mid-word
    do_load(16'hFFFF);
    repeat (5) press(1'b0, 1'b0, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst_bits_left", 32'(bus.bits_left), 32'd0);
    chk("midrst_bit_out", 32'(bus.bit_out), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    m_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) press(1'b0, 1'b0, '0);
    chk_status("post_reset");

    // Randomised words, press counts and bounce
    for (int k = 0; k < 6; k++) begin
      w = WORD_W'($urandom);
      do_load(w);
      n = $urandom_range(1, WORD_W + 3);
      for (int i = 0; i < n; i++) press(1'($urandom_range(0, 1)), 1'b0, '0);
      chk_status("rand");
    end

    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
